// File: rtl/snake_core.sv
// snake_core: parametrised snake engine (segment buffer, turns, wall/self hits, apple, pixel query); define SNAKE_WRAP_EN for wrapping walls
module snake_core #(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    parameter int XW = 7,
    parameter int YW = 6,
    parameter int MAX_LEN = 16,
    parameter int INIT_LEN = 3,
    parameter int SW = 8,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          run,
    input  logic          turn_left,
    input  logic          turn_right,
    input  logic [XW-1:0] apple_x,
    input  logic [YW-1:0] apple_y,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic          is_snake,
    output logic          is_head,
    output logic          crash,
    output logic          suicide,
    output logic          apple_gen,
    output logic [LW-1:0] length,
    output logic [SW-1:0] score
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN = 2'd1;
    localparam logic [1:0] DEAD = 2'd2;
    localparam logic [XW-1:0] HX = XW'(GRID_W / 2);
    localparam logic [YW-1:0] HY = YW'(GRID_H / 2);
    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
    localparam logic [LW-1:0] INIT_L = LW'(INIT_LEN);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

    logic [1:0] state, dir, next_dir;
    logic turn_pend, turn_l, one_turn;
    logic [XW-1:0] seg_x [MAX_LEN];
    logic [YW-1:0] seg_y [MAX_LEN];
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [LW-1:0] chk_len;
    logic wall, eat, self_hit, hit_q, go, commit;

    assign one_turn = turn_left ^ turn_right;
    assign next_dir = !turn_pend ? dir : turn_l ? dir - 2'd1 : dir + 2'd1;
`ifdef SNAKE_WRAP_EN
    assign nx = next_dir == 2'd1 ? (seg_x[0] == XMAX ? '0 : seg_x[0] + XW'(1)) :
                next_dir == 2'd3 ? (seg_x[0] == '0 ? XMAX : seg_x[0] - XW'(1)) : seg_x[0];
    assign ny = next_dir == 2'd2 ? (seg_y[0] == YMAX ? '0 : seg_y[0] + YW'(1)) :
                next_dir == 2'd0 ? (seg_y[0] == '0 ? YMAX : seg_y[0] - YW'(1)) : seg_y[0];
    assign wall = 1'b0;
`else
    assign nx = next_dir == 2'd1 ? seg_x[0] + XW'(1) : next_dir == 2'd3 ? seg_x[0] - XW'(1) : seg_x[0];
    assign ny = next_dir == 2'd2 ? seg_y[0] + YW'(1) : next_dir == 2'd0 ? seg_y[0] - YW'(1) : seg_y[0];
    // stepping left/up from 0 wraps to a large unsigned value, so one upper bound covers both walls
    assign wall = nx > XMAX || ny > YMAX;
`endif
    assign eat = nx == apple_x && ny == apple_y;
    // the tail vacates unless the snake grows on this step
    assign chk_len = eat ? length : length - LW'(1);
    assign go = run && state == RUN && step;
    assign commit = go && !wall && !self_hit;

    // match the next head and the queried pixel against the live segments
    always_comb begin
        self_hit = 1'b0;
        hit_q = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < chk_len && seg_x[i] == nx && seg_y[i] == ny) self_hit = 1'b1;
            if (LW'(i) < length && seg_x[i] == query_x && seg_y[i] == query_y) hit_q = 1'b1;
        end
    end

    // game state, turn latch and body buffer; run low reloads the initial snake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dir <= 2'd1;
            length <= INIT_L;
            turn_pend <= 1'b0;
            turn_l <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= HX - XW'(i);
                seg_y[i] <= HY;
            end
        end else if (!run) begin
            state <= IDLE;
            dir <= 2'd1;
            length <= INIT_L;
            turn_pend <= 1'b0;
            turn_l <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= HX - XW'(i);
                seg_y[i] <= HY;
            end
        end else begin
            if (state == IDLE) state <= RUN;
            if (state != RUN) begin
                turn_pend <= 1'b0;
            end else if (step || !turn_pend) begin
                turn_pend <= one_turn;
                turn_l <= turn_left;
            end
            if (go && (wall || self_hit)) state <= DEAD;
            if (commit) begin
                dir <= next_dir;
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nx;
                seg_y[0] <= ny;
                if (eat && length != MAX_L) length <= length + LW'(1);
            end
        end
    end

    // one-cycle event pulses and saturating score; wall wins over self hit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crash <= 1'b0;
            suicide <= 1'b0;
            apple_gen <= 1'b0;
            score <= '0;
        end else begin
            crash <= go && wall;
            suicide <= go && !wall && self_hit;
            apple_gen <= commit && eat;
            if (commit && eat && score != '1) score <= score + SW'(1);
        end
    end

    // registered pixel query against the body as it stood at the sampling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_snake <= 1'b0;
            is_head <= 1'b0;
        end else begin
            is_snake <= hit_q;
            is_head <= seg_x[0] == query_x && seg_y[0] == query_y;
        end
    end
endmodule

// File: tb/tb_snake_core.sv
// tb_snake_core: directed self-checking bench for snake_core
module tb_snake_core;
    logic clk = 1'b0, rst = 1'b1, step = 1'b0, run = 1'b0, turn_left = 1'b0, turn_right = 1'b0;
    logic [6:0] apple_x = '0, query_x = '0;
    logic [5:0] apple_y = '0, query_y = '0;
    logic is_snake, is_head, crash, suicide, apple_gen;
    logic [4:0] length;
    logic [7:0] score;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    snake_core dut (
        .clk(clk), .rst(rst), .step(step), .run(run),
        .turn_left(turn_left), .turn_right(turn_right),
        .apple_x(apple_x), .apple_y(apple_y),
        .query_x(query_x), .query_y(query_y),
        .is_snake(is_snake), .is_head(is_head),
        .crash(crash), .suicide(suicide), .apple_gen(apple_gen),
        .length(length), .score(score)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic turn(input logic l, input logic r);
        turn_left = l;
        turn_right = r;
        tick();
        turn_left = 1'b0;
        turn_right = 1'b0;
    endtask

    task automatic restart();
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
    endtask

    task automatic set_apple(input int x, input int y);
        apple_x = 7'(x);
        apple_y = 6'(y);
    endtask

    task automatic head_at(input string tag, input int x, input int y);
        query_x = 7'(x);
        query_y = 6'(y);
        tick();
        check(tag, int'(is_head), 1);
    endtask

    // {crash, suicide, apple_gen}
    task automatic pulses(input string tag, input int exp);
        check(tag, int'({crash, suicide, apple_gen}), exp);
    endtask

    initial begin
        int sc, hc, se, he;
        #2 rst = 1'b0;
        tick();
        tick();
        pulses("rst_pulses", 0);
        check("rst_is_snake", int'(is_snake), 0);
        check("rst_is_head", int'(is_head), 0);
        check("rst_length", int'(length), 3);
        check("rst_score", int'(score), 0);
        rst = 1'b1;
        tick();

        sc = 0; hc = 0; se = 0; he = 0;
        for (int y = 0; y < 30; y++) begin
            for (int x = 0; x < 40; x++) begin
                query_x = 7'(x);
                query_y = 6'(y);
                tick();
                sc += int'(is_snake);
                hc += int'(is_head);
                se += int'(is_snake != (y == 15 && x >= 18 && x <= 20));
                he += int'(is_head != (y == 15 && x == 20));
            end
        end
        check("sweep_snake_cnt", sc, 3);
        check("sweep_head_cnt", hc, 1);
        check("sweep_snake_pos", se, 0);
        check("sweep_head_pos", he, 0);

        run = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            do_step();
            pulses("straight_pulses", 0);
        end
        head_at("straight_head", 23, 15);
        check("straight_len", int'(length), 3);

        restart();
        do_step();
        turn(1'b1, 1'b0);
        turn(1'b0, 1'b1);
        do_step();
        head_at("first_turn_head", 21, 14);
        turn(1'b1, 1'b1);
        do_step();
        head_at("both_turn_head", 21, 13);
        turn_right = 1'b1;
        step = 1'b1;
        tick();
        turn_right = 1'b0;
        step = 1'b0;
        head_at("same_cycle_head", 21, 12);
        do_step();
        head_at("deferred_turn_head", 22, 12);

        restart();
        set_apple(21, 15);
        do_step();
        pulses("eat_pulse", 1);
        tick();
        pulses("eat_pulse_end", 0);
        check("eat_len", int'(length), 4);
        check("eat_score", int'(score), 1);
        for (int x = 22; x <= 33; x++) begin
            set_apple(x, 15);
            do_step();
        end
        check("fill_len", int'(length), 16);
        check("fill_score", int'(score), 13);
        set_apple(34, 15);
        do_step();
        pulses("full_eat_pulse", 1);
        check("full_len", int'(length), 16);
        check("full_score", int'(score), 14);
        set_apple(0, 0);
        repeat (5) do_step();
        head_at("edge_head", 39, 15);
        do_step();
`ifdef SNAKE_WRAP_EN
        pulses("wrap_pulses", 0);
        head_at("wrap_head", 0, 15);
`else
        pulses("wall_pulse", 4);
        tick();
        pulses("wall_pulse_end", 0);
        do_step();
        do_step();
        pulses("dead_pulses", 0);
        head_at("dead_head", 39, 15);
        check("dead_len", int'(length), 16);
`endif
        restart();
        check("restart_len", int'(length), 3);
        check("restart_score", int'(score), 14);

        set_apple(21, 15);
        do_step();
        set_apple(22, 15);
        do_step();
        set_apple(0, 0);
        check("len5", int'(length), 5);
        turn(1'b0, 1'b1);
        do_step();
        turn(1'b0, 1'b1);
        do_step();
        turn(1'b0, 1'b1);
        do_step();
        pulses("suicide_pulse", 2);
        head_at("suicide_head", 21, 16);

        restart();
        set_apple(21, 15);
        do_step();
        set_apple(0, 0);
        check("len4", int'(length), 4);
        for (int k = 0; k < 3; k++) begin
            turn(1'b0, 1'b1);
            do_step();
        end
        pulses("tail_pulses", 0);
        head_at("tail_head", 20, 15);
        check("tail_score", int'(score), 17);

        restart();
        set_apple(21, 15);
        run = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        pulses("runfall_pulses", 0);
        check("runfall_score", int'(score), 17);
        check("runfall_len", int'(length), 3);
        run = 1'b1;
        tick();

        do_step();
        pulses("pre_rst_pulse", 1);
        rst = 1'b0;
        #1;
        pulses("async_rst_pulses", 0);
        check("async_rst_score", int'(score), 0);
        check("async_rst_len", int'(length), 3);
        tick();
        rst = 1'b1;
        tick();
        pulses("post_rst_pulses", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/snake_core.md
# snake_core

Parametrised snake engine: the successor to the fixed-size snake control path. Holds the snake body in a MAX_LEN-entry segment buffer and advances it one cell per `step` pulse. Resolves turns, wall/self collisions and apple eating, and answers per-pixel cell queries from the VGA path with one-cycle latency. Sits between the speed/tick generator, the button/brain turn mux and game_control on the input side, and vga/apple on the output side.

## Interface
- GRID_W, 40: playfield width in cells
- GRID_H, 30: playfield height in cells
- XW, 7: x coordinate width
- YW, 6: y coordinate width
- MAX_LEN, 16: segment buffer depth
- INIT_LEN, 3: length after reset/restart, 2..MAX_LEN
- SW, 8: score width
- clk  in  1  system clock, the only clock
- rst  in  1  asynchronous, active-low reset
- step  in  1  one-cycle advance pulse, already synchronous to clk
- run  in  1  game running level from game_control; low holds/restarts
- turn_left, turn_right  in  1  one-cycle turn requests, already muxed
- apple_x / apple_y  in  XW / YW  current apple cell
- query_x / query_y  in  XW / YW  cell under the VGA beam
- is_snake  out  1  query cell holds any segment (registered)
- is_head  out  1  query cell is the head (registered)
- crash  out  1  one-cycle pulse on a wall hit
- suicide  out  1  one-cycle pulse on a self hit
- apple_gen  out  1  one-cycle pulse when the apple is eaten
- length  out  $clog2(MAX_LEN+1)  current segment count
- score  out  SW  apples eaten, saturating

## Operation
- States:
  - IDLE: after reset; body at the initial position.
  - RUN: entered when `run`=1.
  - DEAD: entered from RUN on crash or suicide.
  - Any state with `run`=0 returns to IDLE and reloads the initial body, length and direction. Score is held; it clears only on `rst`.
- Initial body:
  - head at (GRID_W/2, GRID_H/2);
  - segment k at (GRID_W/2−k, GRID_H/2);
  - direction right;
  - length INIT_LEN.
- Direction encoding: 0 up, 1 right, 2 down, 3 left.
  - Left turn: dir−1 mod 4. Right turn: dir+1 mod 4.
- Turn latch:
  - The first request since the last step is held and applied at the next step. Later requests before that step are dropped.
  - turn_left and turn_right asserted in the same cycle are ignored.
  - The latch clears on each step and in IDLE/DEAD.
- On `step` in RUN:
  - Compute the next head from the latched direction.
  - Wall: next head outside 0..GRID_W−1 or 0..GRID_H−1 → crash. Body is frozen and the state goes to DEAD.
  - Eat: next head == (apple_x, apple_y).
  - Self: next head equals a live segment → suicide, DEAD, body frozen.
    - When eating, segments 0..length−1 are checked.
    - Otherwise 0..length−2 are checked, because the tail vacates.
  - Commit:
    - Shift buffer seg[i] ← seg[i−1], seg[0] ← next head.
    - If eating, length increments, saturating at MAX_LEN. At MAX_LEN the snake does not grow, but apple_gen and score still fire.
  - Wall and self hit together report crash only.
- `step` in IDLE or DEAD is ignored.
- Query: compare query_x/query_y against segments 0..length−1. Segments at index ≥ length never match.

## Timing
- Reset values:
  - state IDLE, initial body, direction right, length INIT_LEN;
  - score 0;
  - is_snake, is_head, crash, suicide, apple_gen all 0.
- Step latency:
  - Body, length and score update on the clock edge that samples `step`.
  - crash, suicide and apple_gen are high for exactly the following cycle.
- Query latency: is_snake/is_head reflect the query_x/query_y sampled one clock earlier and the body state at that same edge.
- A turn request in the same cycle as `step` is applied at the next step, not this one.
- `run` falling mid-step: restart wins and no pulse is emitted.
- `rst` asserted mid-operation clears everything immediately; there is no pending pulse after release.

## Configuration
- SNAKE_WRAP_EN:
  - Defined: walls wrap. x −1→GRID_W−1, GRID_W→0; y likewise. crash is never asserted; self-collision still applies.
  - Undefined: wall behaviour as above. crash is asserted and the state enters DEAD.

## Test plan
- Reset, run=1, 3 steps with no turns → head (23,15), length 3, no pulses.
- turn_left then turn_right before one step → only left applied, head moves up to (21,14). Both pressed in the same cycle → straight.
- Apple at (21,15), run, one step → apple_gen high for 1 cycle, length 4, score 1. Fill to MAX_LEN=16 and eat again → length stays 16, score increments.
- Steer into the right wall at x=39, then step →
  - without SNAKE_WRAP_EN: crash pulse, DEAD, further steps ignored;
  - with it: head at x=0, no crash.
- Length 5 snake, turn right three times on consecutive steps → suicide pulse. The same pattern at length 4 into the vacating tail → no suicide.
- Sweep query over the full grid after reset → is_snake at exactly 3 cells and is_head only at (20,15), each one cycle after the query.
